// File: rtl/ro_worker_sequencer.sv
// Job controller for the ring-oscillator worker: reset, load 4 operand bytes, run with timeout,
// read the 32-bit result back and return it with the RUN cycle count over valid/ready handshakes.
module ro_worker_sequencer #(
  parameter int SHIFT_HI = 8,
  parameter int SHIFT_LO = 8,
  parameter int RST_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_start,
  input  logic [15:0] job_count,
  input  logic        job_ring,
  input  logic [15:0] cfg_timeout,
  output logic        wkr_rst_n,
  output logic        wkr_clk_sel,
  output logic        wkr_shift,
  output logic [7:0]  wkr_din,
  input  logic [7:0]  wkr_dout,
  input  logic        wkr_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_value,
  output logic [15:0] res_cycles,
  output logic        res_timeout,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WRST = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_READ = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [15:0] HI_END  = 16'(SHIFT_HI - 1);
  localparam logic [15:0] LO_END  = 16'(SHIFT_LO - 1);
  localparam logic [15:0] RST_END = 16'(RST_CYC - 1);

  logic [2:0]  state;
  logic [31:0] job_word;
  logic [15:0] tmr;
  logic [1:0]  idx;
  logic        hi;
  logic        done_m;
  logic        done_s;
  logic [15:0] cyc_next;
  logic [7:0]  next_byte;

  assign busy     = (state != S_IDLE);
  assign cyc_next = (res_cycles == 16'hFFFF) ? res_cycles : res_cycles + 16'd1;

  // Byte that follows the one currently on wkr_din during LOAD.
  always_comb begin
    next_byte = job_word[7:0];
    case (idx)
      2'd0:    next_byte = job_word[23:16];
      2'd1:    next_byte = job_word[15:8];
      default: next_byte = job_word[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      done_m <= wkr_done;
      done_s <= done_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      job_word    <= '0;
      tmr         <= '0;
      idx         <= '0;
      hi          <= 1'b0;
      job_ready   <= 1'b0;
      wkr_rst_n   <= 1'b0;
      wkr_clk_sel <= 1'b0;
      wkr_shift   <= 1'b0;
      wkr_din     <= '0;
      res_valid   <= 1'b0;
      res_value   <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          job_ready <= 1'b1;
          // A timed-out worker stays in reset until the next job is accepted.
          wkr_rst_n <= ~res_timeout;
          if (job_valid && job_ready) begin
            job_word    <= {job_start, job_count};
            wkr_clk_sel <= job_ring;
            wkr_rst_n   <= 1'b0;
            job_ready   <= 1'b0;
            res_timeout <= 1'b0;
            tmr         <= '0;
            state       <= S_WRST;
          end
        end
        S_WRST: begin
          if (tmr == RST_END) begin
            wkr_rst_n <= 1'b1;
            wkr_din   <= job_word[31:24];
            tmr       <= '0;
            idx       <= '0;
            hi        <= 1'b0;
            state     <= S_LOAD;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        S_LOAD: begin
          if (!hi) begin
            if (tmr == LO_END) begin
              wkr_shift <= 1'b1;
              hi        <= 1'b1;
              tmr       <= '0;
            end else begin
              tmr <= tmr + 16'd1;
            end
          end else if (tmr == HI_END) begin
            wkr_shift <= 1'b0;
            hi        <= 1'b0;
            tmr       <= '0;
            if (idx == 2'd3) begin
              res_cycles <= '0;
              state      <= S_RUN;
            end else begin
              idx     <= idx + 2'd1;
              wkr_din <= next_byte;
            end
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        S_RUN: begin
          if (done_s) begin
            res_cycles <= cyc_next;
            tmr        <= '0;
            idx        <= '0;
            hi         <= 1'b0;
            state      <= S_READ;
          end else if (cfg_timeout != 16'd0 && cyc_next == cfg_timeout) begin
            res_cycles  <= cyc_next;
            res_timeout <= 1'b1;
            res_value   <= '0;
            res_valid   <= 1'b1;
            wkr_rst_n   <= 1'b0;
            state       <= S_RESP;
          end else begin
            res_cycles <= cyc_next;
          end
        end
        S_READ: begin
          if (!hi) begin
            if (tmr == LO_END) begin
              case (idx)
                2'd0:    res_value[31:24] <= wkr_dout;
                2'd1:    res_value[23:16] <= wkr_dout;
                2'd2:    res_value[15:8]  <= wkr_dout;
                default: res_value[7:0]   <= wkr_dout;
              endcase
              tmr <= '0;
              // Only three pulses: a fourth would make the worker start another run.
              if (idx == 2'd3) begin
                res_valid <= 1'b1;
                state     <= S_RESP;
              end else begin
                wkr_shift <= 1'b1;
                hi        <= 1'b1;
              end
            end else begin
              tmr <= tmr + 16'd1;
            end
          end else if (tmr == HI_END) begin
            wkr_shift <= 1'b0;
            hi        <= 1'b0;
            idx       <= idx + 2'd1;
            tmr       <= '0;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_worker_sequencer.sv
// Directed bench for ro_worker_sequencer with a behavioural worker (load, count, rotate readback).
module tb_ro_worker_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid, job_ready, job_ring;
  logic [15:0] job_start, job_count, cfg_timeout;
  logic        wkr_rst_n, wkr_clk_sel, wkr_shift, wkr_done;
  logic [7:0]  wkr_din, wkr_dout;
  logic        res_valid, res_ready, res_timeout, busy;
  logic [31:0] res_value;
  logic [15:0] res_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ro_worker_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_start(job_start), .job_count(job_count), .job_ring(job_ring),
    .cfg_timeout(cfg_timeout),
    .wkr_rst_n(wkr_rst_n), .wkr_clk_sel(wkr_clk_sel), .wkr_shift(wkr_shift),
    .wkr_din(wkr_din), .wkr_dout(wkr_dout), .wkr_done(wkr_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_cycles(res_cycles), .res_timeout(res_timeout), .busy(busy)
  );

  // Worker model: 4 load edges latch ca/db, run increments ca,cb until cb == db+1, readback rotates.
  logic [15:0] ca, cb, db;
  logic [31:0] sr;
  logic [1:0]  scnt;
  logic        running, shift_q, restart_err, suppress_done;
  logic [7:0]  lb [4];
  int          read_edges, run_edges;

  assign wkr_dout = ca[15:8];

  always @(posedge clk or negedge wkr_rst_n) begin
    if (!wkr_rst_n) begin
      ca <= '0; cb <= '0; db <= '0; sr <= '0; scnt <= '0;
      running <= 1'b0; wkr_done <= 1'b0; shift_q <= 1'b0; restart_err <= 1'b0;
      read_edges <= 0; run_edges <= 0;
      for (int i = 0; i < 4; i++) lb[i] <= '0;
    end else begin
      shift_q <= wkr_shift;
      if (running) begin
        if (!suppress_done && ({1'b0, cb} == {1'b0, db} + 17'd1)) begin
          running  <= 1'b0;
          wkr_done <= 1'b1;
        end else begin
          ca <= ca + 16'd1;
          cb <= cb + 16'd1;
        end
      end
      if (wkr_shift && !shift_q) begin
        if (running) begin
          run_edges <= run_edges + 1;
        end else if (wkr_done) begin
          read_edges <= read_edges + 1;
          {ca, cb} <= {ca[7:0], cb, ca[15:8]};
          if (scnt == 2'd3) restart_err <= 1'b1;
          scnt <= scnt + 2'd1;
        end else begin
          lb[scnt] <= wkr_din;
          sr <= {sr[23:0], wkr_din};
          scnt <= scnt + 2'd1;
          if (scnt == 2'd3) begin
            ca <= sr[23:8];
            db <= {sr[7:0], wkr_din};
            cb <= '0;
            running <= 1'b1;
            scnt <= '0;
          end
        end
      end
    end
  end

  task automatic send_job(input logic [15:0] s, input logic [15:0] c, input logic r);
    int n;
    job_start = s; job_count = c; job_ring = r; job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 3000) begin @(negedge clk); n++; end
    tests++;
    if (res_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_res_valid: got %b expected 1 within 3000 cycles", name, res_valid);
    end
  endtask

  task automatic consume(input string name);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_consume: res_valid got %b expected 0", name, res_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({wkr_rst_n, wkr_shift, wkr_clk_sel, res_valid, res_timeout, job_ready, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {wkr_rst_n, wkr_shift, wkr_clk_sel, res_valid, res_timeout, job_ready, busy});
    end
    tests++;
    if ({wkr_din, res_value, res_cycles} !== 56'd0) begin
      fails++;
      $display("FAIL reset_data: din %h value %h cycles %h expected all 0", wkr_din, res_value, res_cycles);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({job_ready, wkr_rst_n, busy} !== 3'b110) begin
      fails++;
      $display("FAIL reset_release: ready/wrst/busy got %b expected 110", {job_ready, wkr_rst_n, busy});
    end
  endtask

  task automatic test_basic;
    send_job(16'h1000, 16'h0005, 1'b0);
    wait_res("basic");
    tests++;
    if ({lb[0], lb[1], lb[2], lb[3]} !== 32'h1000_0005) begin
      fails++;
      $display("FAIL basic_din_bytes: got %h expected 10000005", {lb[0], lb[1], lb[2], lb[3]});
    end
    tests++;
    if (res_value !== 32'h1006_0006 || res_timeout !== 1'b0) begin
      fails++;
      $display("FAIL basic_value: got %h/%b expected 10060006/0", res_value, res_timeout);
    end
    tests++;
    if (res_cycles < 16'd1 || res_cycles > 16'd16) begin
      fails++;
      $display("FAIL basic_cycles: got %0d expected 1..16", res_cycles);
    end
    tests++;
    if (read_edges !== 3 || restart_err !== 1'b0 || run_edges !== 0) begin
      fails++;
      $display("FAIL basic_read_pulses: read %0d restart %b run %0d expected 3 0 0",
               read_edges, restart_err, run_edges);
    end
    tests++;
    if ({wkr_clk_sel, job_ready, busy} !== 3'b001) begin
      fails++;
      $display("FAIL basic_resp_state: sel/ready/busy got %b expected 001", {wkr_clk_sel, job_ready, busy});
    end
    consume("basic");
  endtask

  task automatic test_wrap;
    send_job(16'hFFFF, 16'h0000, 1'b1);
    wait_res("wrap");
    tests++;
    if (res_value !== 32'h0000_0001 || wkr_clk_sel !== 1'b1) begin
      fails++;
      $display("FAIL wrap_value: got %h sel %b expected 00000001 sel 1", res_value, wkr_clk_sel);
    end
    tests++;
    if (res_cycles < 16'd1) begin
      fails++;
      $display("FAIL wrap_cycles: got %0d expected >= 1", res_cycles);
    end
    consume("wrap");
  endtask

  task automatic test_timeout;
    cfg_timeout = 16'd20;
    suppress_done = 1'b1;
    send_job(16'h0100, 16'h0003, 1'b0);
    wait_res("timeout");
    tests++;
    if (res_timeout !== 1'b1 || res_value !== 32'd0 || res_cycles !== 16'd20) begin
      fails++;
      $display("FAIL timeout_result: to %b value %h cycles %0d expected 1 0 20",
               res_timeout, res_value, res_cycles);
    end
    tests++;
    if (wkr_rst_n !== 1'b0 || run_edges !== 0) begin
      fails++;
      $display("FAIL timeout_worker_held: wkr_rst_n %b run_edges %0d expected 0 0", wkr_rst_n, run_edges);
    end
    consume("timeout");
    cfg_timeout = 16'd0;
    suppress_done = 1'b0;
  endtask

  task automatic test_back_to_back;
    int bad;
    int n;
    send_job(16'h1234, 16'h0003, 1'b0);
    wait_res("bp_a");
    job_start = 16'h00FF; job_count = 16'h0002; job_ring = 1'b0; job_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_value !== 32'h1238_0004 || res_timeout !== 1'b0 ||
          job_ready !== 1'b0 || busy !== 1'b1 || wkr_shift !== 1'b0)
        bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL backpressure_hold: %0d unstable cycles, value %h expected 12380004", bad, res_value);
    end
    consume("bp_a");
    n = 0;
    while (!job_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    job_valid = 1'b0;
    wait_res("bp_b");
    tests++;
    if (res_value !== 32'h0102_0003) begin
      fails++;
      $display("FAIL back_to_back_value: got %h expected 01020003", res_value);
    end
    consume("bp_b");
  endtask

  task automatic test_reset_mid_load;
    int n;
    send_job(16'hABCD, 16'h0007, 1'b1);
    n = 0;
    while (!wkr_shift && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (wkr_shift !== 1'b1) begin
      fails++;
      $display("FAIL midload_reach: wkr_shift got %b expected 1", wkr_shift);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({wkr_rst_n, wkr_shift, wkr_clk_sel, res_valid, job_ready, busy, wkr_din} !== 14'd0) begin
      fails++;
      $display("FAIL midload_async_reset: got %b expected all 0",
               {wkr_rst_n, wkr_shift, wkr_clk_sel, res_valid, job_ready, busy, wkr_din});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({job_ready, busy, res_valid, wkr_rst_n} !== 4'b1001) begin
      fails++;
      $display("FAIL midload_idle: ready/busy/valid/wrst got %b expected 1001",
               {job_ready, busy, res_valid, wkr_rst_n});
    end
  endtask

  initial begin
    job_valid = 1'b0; job_start = '0; job_count = '0; job_ring = 1'b0;
    cfg_timeout = '0; res_ready = 1'b0; suppress_done = 1'b0;
    test_reset;
    test_basic;
    test_wrap;
    test_timeout;
    test_back_to_back;
    test_reset_mid_load;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
